// File: rtl/edge_pkg.sv
// Shared definitions for the edge-detection datapath: gradient width,
// direction codes and the tan(22.5°)/tan(67.5°) thresholds in Q10.
package edge_pkg;
  localparam int GRAD_W    = 11;
  localparam int TAN_LO    = 424;
  localparam int TAN_HI    = 2472;
  localparam int TAN_SHIFT = 10;

  typedef enum logic [1:0] {
    ANG_0   = 2'd0,
    ANG_45  = 2'd1,
    ANG_90  = 2'd2,
    ANG_135 = 2'd3
  } ang_t;
endpackage

// File: rtl/arc_tan.sv
// Combinational gradient-direction quantizer: maps (Gx, Gy) to one of four
// direction codes by comparing |Gy| against |Gx| scaled by the Q10 tangents.
module arc_tan
  import edge_pkg::*;
(
  input  logic [GRAD_W-1:0] gx,
  input  logic [GRAD_W-1:0] gy,
  output logic [1:0]        angle
);

  logic signed [GRAD_W-1:0] sgx, sgy;
  logic [GRAD_W-1:0]        ax, ay;
  logic [2*GRAD_W-1:0]      ay_sc, lo_th, hi_th;
  ang_t                     ang;

  assign sgx = gx;
  assign sgy = gy;

  always_comb begin
    // -1024 negates to the 11-bit pattern 1024 when read unsigned
    ax    = sgx[GRAD_W-1] ? GRAD_W'(-sgx) : gx;
    ay    = sgy[GRAD_W-1] ? GRAD_W'(-sgy) : gy;
    ay_sc = (2*GRAD_W)'(ay) << TAN_SHIFT;
    lo_th = (2*GRAD_W)'(ax) * (2*GRAD_W)'(TAN_LO);
    hi_th = (2*GRAD_W)'(ax) * (2*GRAD_W)'(TAN_HI);
    ang   = ANG_0;
    if (gx == '0 && gy == '0)    ang = ANG_0;
    else if (gx == '0)           ang = ANG_90;
    else if (gy == '0)           ang = ANG_0;
    else if (ay_sc <= lo_th)     ang = ANG_0;
    else if (ay_sc >= hi_th)     ang = ANG_90;
    else if (gx[GRAD_W-1] == gy[GRAD_W-1]) ang = ANG_45;
    else                         ang = ANG_135;
    angle = ang;
  end

endmodule

// File: rtl/grad_dir_sched.sv
// Round-robin scheduler sharing one direction quantizer and magnitude unit
// between NREQ gradient lanes; two registered stages, tagged results.
module grad_dir_sched
  import edge_pkg::*;
#(
  parameter  int NREQ  = 2,
  parameter  int MAG_W = 8,
  localparam int SRC_W = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*GRAD_W-1:0] req_gx,
  input  logic [NREQ*GRAD_W-1:0] req_gy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_angle,
  output logic [MAG_W-1:0]       out_mag,
  output logic [SRC_W-1:0]       out_src
);

  localparam logic [SRC_W:0] NREQ_W = (SRC_W+1)'(NREQ);

  function automatic logic [GRAD_W-1:0] abs_g(input logic signed [GRAD_W-1:0] v);
    return v[GRAD_W-1] ? GRAD_W'(-v) : GRAD_W'(v);
  endfunction

  function automatic logic [MAG_W-1:0] sat_mag(input logic [GRAD_W:0] s);
    if (s > (GRAD_W+1)'((1 << MAG_W) - 1)) return '1;
    return s[MAG_W-1:0];
  endfunction

  logic signed [GRAD_W-1:0] gx_p1, gy_p1;
  logic [SRC_W-1:0]         src_p1;
  logic                     vld_p1;
  logic [1:0]               angle_p1;
  logic [MAG_W-1:0]         mag_p1;
  logic [1:0]               angle_p2;
  logic [MAG_W-1:0]         mag_p2;
  logic [SRC_W-1:0]         src_p2;
  logic                     vld_p2;

  logic [SRC_W-1:0]  rr_ptr, grant, nxt_ptr;
  logic [SRC_W:0]    idx;
  logic              any_req, adv_p1, accept_en, hs;
  logic [GRAD_W-1:0] sel_gx, sel_gy;

  assign adv_p1    = vld_p1 & (!vld_p2 | out_ready);
  assign accept_en = !vld_p1 | adv_p1;

  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!any_req && req_valid[idx[SRC_W-1:0]]) begin
        any_req = 1'b1;
        grant   = idx[SRC_W-1:0];
      end
    end
  end

  // Reset and flush both mask the grant so nothing is accepted while they are active
  assign req_ready = (accept_en && any_req && !rst && !clr) ? (NREQ'(1) << grant) : '0;
  assign hs        = |req_ready;
  assign nxt_ptr   = (grant == SRC_W'(NREQ - 1)) ? '0 : grant + SRC_W'(1);
  assign sel_gx    = req_gx[GRAD_W*grant +: GRAD_W];
  assign sel_gy    = req_gy[GRAD_W*grant +: GRAD_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      rr_ptr <= '0;
    end else if (clr) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      rr_ptr <= '0;
    end else begin
      if (hs) begin
        vld_p1 <= 1'b1;
        rr_ptr <= nxt_ptr;
      end else if (adv_p1) begin
        vld_p1 <= 1'b0;
      end
      if (!vld_p2 || out_ready) vld_p2 <= vld_p1;
    end
  end

  // Stage 1: operand register
  always_ff @(posedge clk) begin
    if (hs) begin
      gx_p1  <= sel_gx;
      gy_p1  <= sel_gy;
      src_p1 <= grant;
    end
  end

  arc_tan u_arc_tan (
    .gx    (gx_p1),
    .gy    (gy_p1),
    .angle (angle_p1)
  );

  assign mag_p1 = sat_mag({1'b0, abs_g(gx_p1)} + {1'b0, abs_g(gy_p1)});

  // Stage 2: result register
  always_ff @(posedge clk) begin
    if (adv_p1) begin
      angle_p2 <= angle_p1;
      mag_p2   <= mag_p1;
      src_p2   <= src_p1;
    end
  end

  assign out_valid = vld_p2;
  assign out_angle = vld_p2 ? angle_p2 : '0;
  assign out_mag   = vld_p2 ? mag_p2   : '0;
  assign out_src   = vld_p2 ? src_p2   : '0;

endmodule

// File: tb/tb_grad_dir_sched.sv
// Bench for grad_dir_sched: corner-value table, scoreboard on every transfer,
// plus hand-written fairness, backpressure, reset and flush sequences.
module tb_grad_dir_sched;
  localparam int NREQ  = 2;
  localparam int MAG_W = 8;

  logic                 clk = 1'b0;
  logic                 rst, clr, out_valid, out_ready;
  logic [NREQ-1:0]      req_valid, req_ready;
  logic [NREQ*11-1:0]   req_gx, req_gy;
  logic [1:0]           out_angle;
  logic [MAG_W-1:0]     out_mag;
  logic [0:0]           out_src;
  logic signed [10:0]   gx [NREQ];
  logic signed [10:0]   gy [NREQ];

  assign req_gx = {gx[1], gx[0]};
  assign req_gy = {gy[1], gy[0]};

  grad_dir_sched #(.NREQ(NREQ), .MAG_W(MAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_gx    (req_gx),
    .req_gy    (req_gy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_angle (out_angle),
    .out_mag   (out_mag),
    .out_src   (out_src)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] angle;
    logic [7:0] mag;
    logic [0:0] src;
  } res_t;

  typedef struct {
    int gx;
    int gy;
    int ang;
    int mag;
  } vec_t;

  res_t sb[$];
  res_t exp_r;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic res_t model(input int x, input int y, input int s);
    int ax, ay, m, a;
    res_t r;
    ax = (x < 0) ? -x : x;
    ay = (y < 0) ? -y : y;
    m  = (ax + ay > 255) ? 255 : ax + ay;
    if (x == 0 && y == 0)           a = 0;
    else if (x == 0)                a = 2;
    else if (y == 0)                a = 0;
    else if (ay * 1024 <= ax * 424)  a = 0;
    else if (ay * 1024 >= ax * 2472) a = 2;
    else if ((x < 0) == (y < 0))    a = 1;
    else                            a = 3;
    r.angle = 2'(a);
    r.mag   = 8'(m);
    r.src   = 1'(s);
    return r;
  endfunction

  // Scoreboard: push on each accepted request, pop on each output transfer
  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++)
      if (req_valid[i] && req_ready[i]) sb.push_back(model(gx[i], gy[i], i));
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_output", 1, 0);
      else begin
        exp_r = sb.pop_front();
        chk("sb_angle", int'(out_angle), int'(exp_r.angle));
        chk("sb_mag",   int'(out_mag),   int'(exp_r.mag));
        chk("sb_src",   int'(out_src),   int'(exp_r.src));
      end
    end
  end

  vec_t tv[12];
  int   got, acc, prev_g, prev_src, s_ang, s_mag, s_src;

  initial begin
    tv[0]  = '{100, 10, 0, 110};
    tv[1]  = '{-1024, -1024, 1, 255};
    tv[2]  = '{0, 5, 2, 5};
    tv[3]  = '{0, 0, 0, 0};
    tv[4]  = '{10, -10, 3, 20};
    tv[5]  = '{10, -25, 2, 35};
    tv[6]  = '{-300, 100, 0, 255};
    tv[7]  = '{-50, -20, 0, 70};
    tv[8]  = '{-50, -21, 1, 71};
    tv[9]  = '{-5, 0, 0, 5};
    tv[10] = '{3, -100, 2, 103};
    tv[11] = '{10, -24, 3, 34};

    rst = 1'b1; clr = 1'b0; out_ready = 1'b1; req_valid = '1;
    gx[0] = '0; gy[0] = '0; gx[1] = '0; gy[1] = '0;
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_out_mag",   int'(out_mag),   0);
    chk("rst_out_angle", int'(out_angle), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; req_valid = '0;

    // single item latency
    @(posedge clk); #1 req_valid = 2'b01; gx[0] = 11'sd100; gy[0] = 11'sd10;
    @(negedge clk); chk("single_ready", int'(req_ready), 1);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk); chk("single_lat_n1", int'(out_valid), 0);
    @(negedge clk);
    chk("single_valid", int'(out_valid), 1);
    chk("single_angle", int'(out_angle), 0);
    chk("single_mag",   int'(out_mag),   110);
    chk("single_src",   int'(out_src),   0);

    // corner-value table
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1 gx[0] = 11'(tv[i].gx); gy[0] = 11'(tv[i].gy); req_valid = 2'b01;
      got = 0;
      for (int c = 0; c < 10 && got == 0; c++) begin
        @(negedge clk);
        if (req_ready[0]) got = 1;
      end
      chk("vec_accept", got, 1);
      @(posedge clk); #1 req_valid = '0;
      got = 0;
      for (int c = 0; c < 10 && got == 0; c++) begin
        @(negedge clk);
        if (out_valid) got = 1;
      end
      chk("vec_out_valid", got, 1);
      chk("vec_angle", int'(out_angle), tv[i].ang);
      chk("vec_mag",   int'(out_mag),   tv[i].mag);
      chk("vec_src",   int'(out_src),   0);
    end

    // fairness: last grant was lane 0, so lane 1 goes first
    gx[0] = 11'sd20; gy[0] = 11'sd5; gx[1] = 11'sd5; gy[1] = 11'sd20;
    @(posedge clk); #1 req_valid = 2'b11;
    prev_g = 0; prev_src = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("fair_onehot", int'($onehot(req_ready)), 1);
      if (i == 0) chk("fair_first", int'(req_ready), 2);
      else        chk("fair_alt", int'(req_ready), (prev_g == 1) ? 2 : 1);
      prev_g = int'(req_ready);
      if (i >= 2) begin
        chk("fair_out_valid", int'(out_valid), 1);
        if (i >= 3) chk("fair_src_alt", int'(out_src), 1 - prev_src);
        prev_src = int'(out_src);
      end
    end
    @(posedge clk); #1 req_valid = '0;
    repeat (4) @(negedge clk);

    // backpressure
    @(posedge clk); #1 out_ready = 1'b0; req_valid = 2'b11;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (|req_ready) acc++;
    end
    chk("bp_accepts", acc, 2);
    chk("bp_ready_low", int'(req_ready), 0);
    s_ang = int'(out_angle); s_mag = int'(out_mag); s_src = int'(out_src);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_held", int'(out_valid), 1);
      chk("bp_angle_stable", int'(out_angle), s_ang);
      chk("bp_mag_stable",   int'(out_mag),   s_mag);
      chk("bp_src_stable",   int'(out_src),   s_src);
    end
    @(posedge clk); #1 req_valid = '0; out_ready = 1'b1;
    for (int c = 0; c < 10 && sb.size() != 0; c++) @(negedge clk);
    chk("bp_drain_empty", sb.size(), 0);

    // asynchronous reset mid-stream, rr_ptr left at 1 beforehand
    @(posedge clk); #1 req_valid = 2'b01;
    repeat (3) @(negedge clk);
    chk("pre_rst_valid", int'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_req_ready", int'(req_ready), 0);
    chk("arst_out_mag",   int'(out_mag),   0);
    @(posedge clk); #1 sb.delete(); rst = 1'b0; req_valid = 2'b11;
    @(negedge clk); chk("arst_first_grant", int'(req_ready), 1);
    chk("arst_no_output", int'(out_valid), 0);

    // synchronous flush, rr_ptr left at 1 beforehand
    @(posedge clk); #1 req_valid = 2'b01;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 clr = 1'b1; out_ready = 1'b0; req_valid = 2'b11;
    @(negedge clk);
    chk("clr_same_cycle_ready", int'(req_ready), 0);
    chk("clr_pre_edge_valid",   int'(out_valid), 1);
    @(posedge clk); #1 clr = 1'b0; out_ready = 1'b1; sb.delete();
    #1;
    chk("clr_out_valid", int'(out_valid), 0);
    chk("clr_first_grant", int'(req_ready), 1);
    @(posedge clk); #1 req_valid = '0;
    for (int c = 0; c < 10 && sb.size() != 0; c++) @(negedge clk);
    chk("clr_drain_empty", sb.size(), 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
